// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU: FSM state encoding and instruction field positions.
package hack_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    // C-instruction field positions
    localparam int A_BIT    = 12;
    localparam int COMP_MSB = 11;
    localparam int COMP_LSB = 6;
    localparam int D_A      = 5;
    localparam int D_D      = 4;
    localparam int D_M      = 3;
    localparam int J_LT     = 2;
    localparam int J_EQ     = 1;
    localparam int J_GT     = 0;

    // Jump condition from the three jump bits and the ALU flags.
    function automatic logic jump_taken(input logic [2:0] jbits, input logic zr, input logic ng);
        return (jbits[J_LT] & ng) | (jbits[J_EQ] & zr) | (jbits[J_GT] & ~ng & ~zr);
    endfunction

endpackage

// File: rtl/hack_alu.sv
// Combinational Hack ALU: optional zero/negate on each input, add or AND, optional output negate.
module hack_alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng,
    output logic        carry_out
);

    logic [15:0] x_z, x_n, y_z, y_n, f_out;
    logic [16:0] sum;

    // Pre-process operands, compute the function, post-process the result
    always_comb begin
        x_z       = zx ? 16'h0000 : x;
        x_n       = nx ? ~x_z : x_z;
        y_z       = zy ? 16'h0000 : y;
        y_n       = ny ? ~y_z : y_z;
        sum       = {1'b0, x_n} + {1'b0, y_n};
        f_out     = f ? sum[15:0] : (x_n & y_n);
        out       = no ? ~f_out : f_out;
        zr        = (out == 16'h0000);
        ng        = out[15];
        carry_out = f & sum[16];
    end

endmodule

// File: rtl/hack_cpu.sv
// Multi-cycle Hack CPU: fetches over a req/ack port, executes through hack_alu,
// and accesses data memory over a second req/ack port.
module hack_cpu
    import hack_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        instr_req,
    output logic [15:0] instr_addr,
    input  logic        instr_ack,
    input  logic [15:0] instr_data,
    output logic        mem_rd_req,
    output logic        mem_wr_req,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        retire
);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] a_q, a_d;
    logic [15:0] d_q, d_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] mreg_q, mreg_d;
    logic        instr_req_q, instr_req_d;
    logic        mem_rd_req_q, mem_rd_req_d;
    logic        mem_wr_req_q, mem_wr_req_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        retire_c;

    logic [15:0] alu_y;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic        alu_carry;
    logic [5:0]  comp;

    // Y operand is M when the a-bit is set, otherwise the A register as it was before this instruction
    assign alu_y = ir_q[A_BIT] ? mreg_q : a_q;
    assign comp  = ir_q[COMP_MSB:COMP_LSB];

    hack_alu u_alu (
        .x         (d_q),
        .y         (alu_y),
        .zx        (comp[5]),
        .nx        (comp[4]),
        .zy        (comp[3]),
        .ny        (comp[2]),
        .f         (comp[1]),
        .no        (comp[0]),
        .out       (alu_out),
        .zr        (alu_zr),
        .ng        (alu_ng),
        .carry_out (alu_carry)
    );

    // Ignored instruction bits and the ALU carry are deliberately left unconnected to any logic
    logic unused_bits;
    assign unused_bits = &{1'b0, ir_q[14:13], alu_carry};

    // Next-state, register updates and registered request outputs
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned and infers a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        a_d          = a_q;
        d_d          = d_q;
        ir_d         = ir_q;
        mreg_d       = mreg_q;
        instr_req_d  = instr_req_q;
        mem_rd_req_d = mem_rd_req_q;
        mem_wr_req_d = mem_wr_req_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        retire_c     = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                if (!instr_req_q) begin
                    // First cycle after reset: raise the fetch request
                    instr_req_d = 1'b1;
                end else if (instr_ack) begin
                    ir_d        = instr_data;
                    instr_req_d = 1'b0;
                    if (instr_data[15] && instr_data[A_BIT]) begin
                        mem_rd_req_d = 1'b1;
                        mem_addr_d   = a_q;
                        state_d      = ST_READ;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end

            ST_READ: begin
                if (mem_ack) begin
                    mreg_d       = mem_rdata;
                    mem_rd_req_d = 1'b0;
                    state_d      = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (!ir_q[15]) begin
                    a_d         = {1'b0, ir_q[14:0]};
                    pc_d        = pc_q + 16'd1;
                    retire_c    = 1'b1;
                    instr_req_d = 1'b1;
                    state_d     = ST_FETCH;
                end else begin
                    if (ir_q[D_A]) a_d = alu_out;
                    if (ir_q[D_D]) d_d = alu_out;
                    pc_d = jump_taken(ir_q[2:0], alu_zr, alu_ng) ? a_q : pc_q + 16'd1;
                    if (ir_q[D_M]) begin
                        mem_wr_req_d = 1'b1;
                        mem_addr_d   = a_q;
                        mem_wdata_d  = alu_out;
                        state_d      = ST_WRITE;
                    end else begin
                        retire_c    = 1'b1;
                        instr_req_d = 1'b1;
                        state_d     = ST_FETCH;
                    end
                end
            end

            ST_WRITE: begin
                if (mem_ack) begin
                    mem_wr_req_d = 1'b0;
                    retire_c     = 1'b1;
                    instr_req_d  = 1'b1;
                    state_d      = ST_FETCH;
                end
            end

            default: state_d = ST_FETCH;
        endcase
    end

    // State register with asynchronous clear of all state and requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            a_q          <= 16'h0000;
            d_q          <= 16'h0000;
            ir_q         <= 16'h0000;
            mreg_q       <= 16'h0000;
            instr_req_q  <= 1'b0;
            mem_rd_req_q <= 1'b0;
            mem_wr_req_q <= 1'b0;
            mem_addr_q   <= 16'h0000;
            mem_wdata_q  <= 16'h0000;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values computed above.
            state_q      <= state_d;
            pc_q         <= pc_d;
            a_q          <= a_d;
            d_q          <= d_d;
            ir_q         <= ir_d;
            mreg_q       <= mreg_d;
            instr_req_q  <= instr_req_d;
            mem_rd_req_q <= mem_rd_req_d;
            mem_wr_req_q <= mem_wr_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign instr_req  = instr_req_q;
    assign instr_addr = pc_q;
    assign mem_rd_req = mem_rd_req_q;
    assign mem_wr_req = mem_wr_req_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign retire     = retire_c;

endmodule

// File: doc/hack_cpu.md
# hack_cpu

Multi-cycle Hack CPU core that issues instructions to the existing `hack_alu` rather than being driven by a bench. It fetches 16-bit Hack instructions over a request/acknowledge port and holds the A, D and PC registers. It decodes C-instruction comp bits into the ALU's `zX nX zY nY f no` controls, reads and writes data memory over a second request/acknowledge port, and evaluates jumps.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- Clock and reset are a single clock domain; reset is asynchronous and active-low.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `instr_req`  output  1  instruction fetch request.
- `instr_addr`  output  16  fetch address (equals PC).
- `instr_ack`  input  1  fetch accepted; `instr_data` is valid in the same cycle.
- `instr_data`  input  16  instruction word.
- `mem_rd_req`  output  1  data read request.
- `mem_wr_req`  output  1  data write request.
- `mem_addr`  output  16  data address (A register).
- `mem_wdata`  output  16  write data (ALU out).
- `mem_rdata`  input  16  read data; valid when `mem_ack` is high.
- `mem_ack`  input  1  read or write completed this cycle.
- `retire`  output  1  one-cycle pulse when an instruction completes.

## Operation
- States: FETCH, READ, EXEC, WRITE.
- FETCH: hold `instr_req`=1 with `instr_addr`=PC until `instr_ack`, then latch IR.
  - If `IR[15]`=0 (A-instruction), go to EXEC.
  - If C-instruction with `IR[12]`=1 (a-bit, operand is M), go to READ.
  - Otherwise go to EXEC.
- READ: hold `mem_rd_req`=1, `mem_addr`=A until `mem_ack`; latch `mem_rdata` into MREG; go to EXEC.
- EXEC:
  - A-instruction: A <= {1'b0, `IR[14:0]`}; PC <= PC+1; `retire`; go to FETCH.
  - C-instruction ALU inputs: X=D; Y = a-bit ? MREG : A.
  - C-instruction ALU controls: `zX nX zY nY f no` = `IR[11:6]`.
  - Flags from ALU out: zr = (out==0); ng = out[15].
  - Destinations: `IR[5]` loads A, `IR[4]` loads D, `IR[3]` writes M.
  - Jump if (`IR[2]`&ng) | (`IR[1]`&zr) | (`IR[0]`&!ng&!zr). Jump sets PC <= old A; otherwise PC <= PC+1, wrapping 16'hFFFF -> 0.
  - If `IR[3]`=1, latch ALU out and old A for the write and go to WRITE. Otherwise `retire` and go to FETCH.
- WRITE: hold `mem_wr_req`=1, `mem_addr`=old A, `mem_wdata`=latched out until `mem_ack`; then `retire`; go to FETCH.
- All uses of A inside one instruction (Y operand, M address, jump target) see A from before that instruction's A update. This covers dest AM and dest A with a jump.
- `IR[14:13]` are ignored. `carry_out` from `hack_alu` is unused.

## Timing
- Reset values: PC=`RESET_PC`, A=0, D=0, IR=0, MREG=0, state=FETCH.
- Reset output values: `instr_req`=0, `mem_rd_req`=0, `mem_wr_req`=0, `mem_addr`=0, `mem_wdata`=0, `retire`=0.
- `instr_req` rises in the first cycle after `rst_n` deasserts.
- Request outputs are registered and stay stable until acknowledged. An ack in the first cycle of a request completes that cycle.
- `instr_ack` outside FETCH and `mem_ack` outside READ/WRITE are ignored.
- `mem_rd_req` and `mem_wr_req` are never high together. `instr_req` and any mem request are never high together.
- Minimum latency with zero-wait acks:
  - A-instruction: 2 cycles.
  - C-instruction without M: 2 cycles.
  - +1 cycle with M read; +1 cycle with M write.
- `rst_n` low in any state clears every request immediately (asynchronously); no partial register update survives.

## Structure
- Package `hack_pkg` holds:
  - state encoding (FETCH=0, READ=1, EXEC=2, WRITE=3);
  - field constants: A_BIT=12, COMP_MSB=11, COMP_LSB=6, D_A=5, D_D=4, D_M=3, J_LT=2, J_EQ=1, J_GT=0.
- Instantiates the existing `hack_alu` as its one sub-module; the ALU stays combinational.

## Test plan
- Reset then `@5` (16'h0005), `D=A` (16'hEC10), zero-wait acks:
  - fetch addresses are 0 then 1;
  - A=5, D=5, PC=2;
  - `retire` pulses in cycles 2 and 4.
- With A=5, D=5: `D=D+A` (16'hE090) -> D=16'h000A, no mem request.
- With A=5, D=10: `M=D` (16'hE308), `mem_ack` delayed 3 cycles:
  - `mem_wr_req` held 3 cycles with addr 5, wdata 16'h000A;
  - `retire` only after ack.
- With A=5: `D=M` (16'hFC10), `mem_rdata`=16'h1234 -> `mem_rd_req` at addr 5, then D=16'h1234.
- Jumps:
  - A=5, `0;JMP` (16'hEA87) -> next fetch address 5.
  - D=0, `D;JGT` (16'hE301) at PC=7 -> next fetch address 8.
- Reset during READ with `mem_ack` held low:
  - requests drop in the same cycle;
  - PC=0, A=0, D=0;
  - fetch restarts at 0.
